// File: rtl/uart_transmitter_if.sv
// Byte handshake between a host and uart_transmitter.
//   tx_data  : byte offered by the host
//   tx_valid : host has a byte on tx_data
//   tx_ready : transmitter holding register is empty; a byte is taken on
//              any rising edge where tx_valid && tx_ready
// master = host side, slave = transmitter side.
interface uart_transmitter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_transmitter.sv
// Serial 8N1 UART transmitter. One byte per handshake is shifted out on tx
// as a start bit, 8 data bits LSB first and a stop bit. A one-entry holding
// register lets the host queue the next byte while a frame is on the line,
// so frames go out back-to-back with no idle gap.
//
// Ports:
//   clk_1MHz : clock, rising edge (frequency given by CLK_FREQ)
//   rst      : synchronous, active-high reset
//   host     : handshake interface (tx_data, tx_valid in; tx_ready out)
//   tx       : registered serial line, idles high
//   busy     : a frame is on the line
//   tx_done  : one-cycle pulse at the edge that ends a stop bit
module uart_transmitter #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                clk_1MHz,
    input  logic                rst,
    uart_transmitter_if.slave   host,
    output logic                tx,
    output logic                busy,
    output logic                tx_done
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] LAST_CNT     = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state;
    logic [7:0]  hold_data;
    logic        hold_full;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic [15:0] cnt;
    logic        accept;
    logic        bit_end;

    // Ready depends only on the holding register, so an accept can never
    // coincide with the FSM draining that register on the same edge.
    assign host.tx_ready = !hold_full;
    assign accept        = host.tx_valid && !hold_full;
    assign bit_end       = (cnt == LAST_CNT);

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            hold_full <= 1'b0;
            shreg     <= 8'd0;
            bit_cnt   <= 3'd0;
            cnt       <= 16'd0;
        end else begin
            tx_done <= 1'b0;

            if (accept) begin
                hold_full <= 1'b1;
                hold_data <= host.tx_data;
            end

            // Outputs are assigned for the state being entered, so tx and
            // busy change on the same edge as the state transition.
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (hold_full) begin
                        shreg     <= hold_data;
                        hold_full <= 1'b0;
                        cnt       <= 16'd0;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        cnt     <= 16'd0;
                        bit_cnt <= 3'd0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        cnt   <= 16'd0;
                        shreg <= shreg >> 1;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Next data bit is the one about to shift into bit 0.
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        cnt     <= 16'd0;
                        tx_done <= 1'b1;
                        if (hold_full) begin
                            // Chain straight into the next start bit.
                            shreg     <= hold_data;
                            hold_full <= 1'b0;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter (CLKS_PER_BIT = 16). Accepted bytes are
// queued as expectations; an independent line monitor reconstructs each
// frame from tx and compares it with the 10-bit 8N1 frame of the queued byte.
module tb_uart_transmitter;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;
    localparam int FRAME     = 10 * CPB;

    logic clk_1MHz = 1'b0;
    logic rst      = 1'b1;
    logic tx;
    logic busy;
    logic tx_done;

    uart_transmitter_if bus();

    uart_transmitter #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk_1MHz(clk_1MHz),
        .rst     (rst),
        .host    (bus.slave),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk_1MHz = ~clk_1MHz;

    int         checks      = 0;
    int         failures    = 0;
    int         cyc         = 0;
    int         frames_done = 0;
    logic [7:0] exp_q[$];
    int         acc_cyc[$];
    int         start_cyc[$];
    int         done_cyc[$];

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Accept observer: every byte taken by the handshake becomes an expectation.
    always @(posedge clk_1MHz) begin
        cyc <= cyc + 1;
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            exp_q.push_back(bus.tx_data);
            acc_cyc.push_back(cyc + 1);
        end
    end

    // Line monitor: sample 1 time unit after each edge.
    initial begin : monitor
        int         k;
        int         bad;
        int         first_bad;
        bit         in_frame;
        bit         just_ended;
        logic [9:0] fb;
        logic [7:0] got;
        logic [7:0] want;
        k = 0; bad = 0; first_bad = -1; in_frame = 0;
        fb = '1; got = '0; want = '0;
        forever begin
            @(posedge clk_1MHz);
            #1;
            just_ended = 0;
            if (rst) begin
                in_frame = 0;
                continue;
            end
            if (in_frame) begin
                k++;
                if (k == FRAME) begin
                    check(tx_done === 1'b1, "done_pulse", int'(tx_done), 1);
                    check(bad == 0, "frame_shape_first_bad_cycle", first_bad, -1);
                    check(got == want, "frame_byte", int'(got), int'(want));
                    done_cyc.push_back(cyc);
                    frames_done++;
                    in_frame   = 0;
                    just_ended = 1;
                end else begin
                    if (tx !== fb[k / CPB] || tx_done !== 1'b0 || busy !== 1'b1) begin
                        if (bad == 0) first_bad = k;
                        bad++;
                    end
                    if ((k % CPB) == CPB / 2 && (k / CPB) >= 1 && (k / CPB) <= 8)
                        got[(k / CPB) - 1] = tx;
                end
            end
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_frame", 1, 0);
                        want = 8'h00;
                    end else begin
                        want = exp_q.pop_front();
                    end
                    fb        = {1'b1, want, 1'b0};
                    k         = 0;
                    bad       = 0;
                    first_bad = -1;
                    got       = 8'h00;
                    in_frame  = 1;
                    start_cyc.push_back(cyc);
                    check(busy === 1'b1, "busy_at_start", int'(busy), 1);
                end else if (just_ended) begin
                    check(busy === 1'b0, "busy_fall_at_done", int'(busy), 0);
                end else begin
                    check(busy === 1'b0 && tx_done === 1'b0, "idle_outputs",
                          int'({busy, tx_done}), 0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, output int acc);
        int n;
        bit r;
        n = 0;
        @(negedge clk_1MHz);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        forever begin
            r = bus.tx_ready;
            @(posedge clk_1MHz);
            if (r) break;
            n++;
            if (n > 5000) begin
                check(1'b0, "send_timeout", n, 5000);
                break;
            end
            @(negedge clk_1MHz);
        end
        acc = cyc + 1;
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < 5000) begin
            @(posedge clk_1MHz);
            n++;
        end
        #2;
        check(frames_done >= target, name, frames_done, target);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk_1MHz);
            #2;
            n++;
        end while (!(exp_q.size() == 0 && busy === 1'b0 && bus.tx_ready === 1'b1) && n < 8000);
        check(n < 8000, name, n, 8000);
    endtask

    initial begin : stimulus
        int a0, a1, f, d, s, i0, st;
        logic [7:0] rb;

        // Reset held for 3 cycles with a byte offered.
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h55;
        repeat (3) begin
            @(posedge clk_1MHz);
            #1;
            check(tx === 1'b1 && bus.tx_ready === 1'b1 && busy === 1'b0 && tx_done === 1'b0,
                  "reset_outputs", int'({tx, bus.tx_ready, busy, tx_done}), 4'b1100);
        end
        @(negedge clk_1MHz);
        rst          = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (40) @(posedge clk_1MHz);
        #1;
        check(tx === 1'b1 && busy === 1'b0 && frames_done == 0 && start_cyc.size() == 0,
              "nothing_accepted_in_reset", start_cyc.size(), 0);

        // Single frame 0xA5: latency and frame length.
        f = frames_done;
        send(8'hA5, a0);
        check(bus.tx_ready === 1'b0 && tx === 1'b1, "ready_low_after_accept",
              int'({bus.tx_ready, tx}), 2'b01);
        @(posedge clk_1MHz);
        #1;
        check(tx === 1'b0 && busy === 1'b1 && bus.tx_ready === 1'b1, "load_edge",
              int'({tx, busy, bus.tx_ready}), 3'b011);
        wait_frames(f + 1, "a5_frame_done");
        s = start_cyc.size();
        d = done_cyc.size();
        check(start_cyc[s - 1] == a0 + 1, "start_latency", start_cyc[s - 1] - a0, 1);
        check(done_cyc[d - 1] - start_cyc[s - 1] == FRAME, "frame_length",
              done_cyc[d - 1] - start_cyc[s - 1], FRAME);

        // Back-to-back 0x00 then 0xFF.
        repeat (5) @(negedge clk_1MHz);
        f = frames_done;
        send(8'h00, a0);
        send(8'hFF, a1);
        wait_frames(f + 2, "b2b_frames_done");
        s = start_cyc.size();
        d = done_cyc.size();
        check(start_cyc[s - 1] == done_cyc[d - 2], "b2b_no_gap",
              start_cyc[s - 1] - done_cyc[d - 2], 0);
        check(done_cyc[d - 1] - done_cyc[d - 2] == FRAME, "b2b_done_spacing",
              done_cyc[d - 1] - done_cyc[d - 2], FRAME);

        // tx_valid held high with changing data while the register is full.
        wait_idle("idle_before_hold");
        i0 = acc_cyc.size();
        repeat (3 * FRAME) begin
            @(negedge clk_1MHz);
            bus.tx_valid = 1'b1;
            bus.tx_data  = 8'($urandom);
        end
        @(negedge clk_1MHz);
        bus.tx_valid = 1'b0;
        wait_idle("idle_after_hold");
        check(acc_cyc.size() - i0 >= 3, "hold_accept_count", acc_cyc.size() - i0, 3);
        for (int i = i0; i + 2 < acc_cyc.size(); i++)
            check(acc_cyc[i + 2] - acc_cyc[i] >= FRAME, "two_accepts_per_frame",
                  acc_cyc[i + 2] - acc_cyc[i], FRAME);

        // Random bytes with random gaps.
        repeat (6) begin
            rb = 8'($urandom);
            send(rb, a0);
            repeat ($urandom_range(0, 40)) @(negedge clk_1MHz);
        end
        wait_idle("idle_after_random");

        // Reset in the middle of data bit 3 with a byte queued.
        f  = frames_done;
        st = start_cyc.size();
        send(8'hC3, a0);
        send(8'h96, a1);
        check(start_cyc.size() == st + 1, "mid_reset_frame_started", start_cyc.size(), st + 1);
        while (cyc < start_cyc[start_cyc.size() - 1] + 4 * CPB + CPB / 2)
            @(negedge clk_1MHz);
        @(negedge clk_1MHz);
        rst = 1'b1;
        @(posedge clk_1MHz);
        #1;
        check(tx === 1'b1 && bus.tx_ready === 1'b1 && busy === 1'b0 && tx_done === 1'b0,
              "mid_frame_reset_outputs", int'({tx, bus.tx_ready, busy, tx_done}), 4'b1100);
        exp_q.delete();
        @(negedge clk_1MHz);
        rst = 1'b0;
        repeat (2 * FRAME) @(posedge clk_1MHz);
        #1;
        check(tx === 1'b1 && busy === 1'b0 && frames_done == f, "queued_byte_discarded",
              frames_done - f, 0);
        send(8'h3C, a0);
        wait_frames(f + 1, "after_reset_frame_done");

        wait_idle("final_idle");
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial 8N1 UART transmitter: accepts one byte per valid/ready handshake and shifts it out on `tx` as one start bit, 8 data bits LSB first, and one stop bit. It is the transmit-side counterpart of `uart_receiver` and shares its baud arithmetic, so a `tx` → `dataValue` loopback with matching parameters reproduces every byte. A one-entry holding register lets the host queue the next byte while the current frame is on the line, so frames can go out back-to-back.

## Interface
- `CLK_FREQ`, default 100_000_000: frequency of `clk_1MHz` in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- `CLKS_PER_BIT` (localparam) = `CLK_FREQ / BAUD_RATE`, integer division; 10416 at defaults. Must be ≥ 2 and < 2^16.
- `clk_1MHz`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_data`  in  8  byte to send; sampled only on an accepted handshake.
- `tx_valid`  in  1  host offers `tx_data`.
- `tx_ready`  out  1  holding register empty; handshake completes on an edge where `tx_valid && tx_ready`.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  a frame is on the line (state ≠ IDLE).
- `tx_done`  out  1  one-cycle pulse when a stop bit completes.

## Operation
- Holding register: `hold_data[7:0]` and `hold_full`. An accept sets `hold_full` and stores `tx_data`. `tx_ready = !hold_full`, driven combinationally from the register. No accept is possible while full, so an accept and a load can never happen on the same edge.
- Shift register `shreg[7:0]`, bit index `bit_cnt[2:0]`, and baud counter `cnt[15:0]`. `cnt` counts 0 to `CLKS_PER_BIT-1`, then wraps to 0.
- FSM states:
  - IDLE: `tx`=1. If `hold_full`: load `shreg<=hold_data`, clear `hold_full`, `cnt<=0`, go to START.
  - START: `tx`=0. When `cnt==CLKS_PER_BIT-1`: set `bit_cnt<=0` and go to DATA.
  - DATA: `tx=shreg[0]`. When `cnt==CLKS_PER_BIT-1`: shift `shreg` right. If `bit_cnt==7`, go to STOP; otherwise increment `bit_cnt`.
  - STOP: `tx`=1. When `cnt==CLKS_PER_BIT-1`: pulse `tx_done`. If `hold_full`, load it as in IDLE and go directly to START with no idle gap. Otherwise go to IDLE.
- `tx` is a register: its value for a state appears from the edge that enters that state.
- `tx_data` changes while not accepted are ignored. The byte on the line is never affected by new accepts.
- Reset, including mid-frame, forces:
  - state=IDLE, `tx`=1, `hold_full`=0 (queued byte discarded), `cnt`=0, `bit_cnt`=0, `shreg`=0
  - `tx_ready`=1, `busy`=0, `tx_done`=0
  
  These values appear at the first edge with `rst` high. A partially sent frame is abandoned, and the line simply returns high.

## Timing
- Accept at edge N with FSM in IDLE:
  - `hold_full`=1 and `tx_ready`=0 after N.
  - At edge N+1, the FSM loads the byte: `tx`=0, `busy`=1, `tx_ready`=1.
- Each of start, 8 data, and stop bits lasts exactly `CLKS_PER_BIT` cycles. A frame is `10*CLKS_PER_BIT` cycles from the start edge to the end of the stop bit.
- `tx_done` is high for exactly one cycle, starting at the edge that ends the stop bit.
  - Back-to-back frames: the same edge drives `tx` low for the next start bit.
  - Otherwise: `busy` falls at that edge.
- Throughput: one byte per `10*CLKS_PER_BIT` cycles when the host keeps the holding register full.
- `tx_valid` held high while `tx_ready`=0 causes no accept and does not corrupt state.

## Test plan
- Override `CLK_FREQ`=1_600_000 and `BAUD_RATE`=100_000 (`CLKS_PER_BIT`=16), then send 0xA5 → `tx` is:
  - low for 16 cycles,
  - then 1,0,1,0,0,1,0,1 at 16 cycles each,
  - then high for 16 cycles.
  
  `tx_done` pulses once at cycle 160 after the start edge; `busy` falls on that same edge.
- Same parameters: accept 0x00, then 0xFF as soon as `tx_ready` returns → 20 contiguous bit periods with no idle cycle between the first stop bit and the second start bit; `tx_done` pulses twice, 160 cycles apart.
- Hold `tx_valid`=1 with changing `tx_data` while the register is full → only bytes presented on edges with `tx_ready`=1 are transmitted; there are exactly two accepts per frame interval at most.
- Assert `rst` for one cycle mid-way through data bit 3 with a second byte queued → `tx`=1, `tx_ready`=1, `busy`=0 from the reset edge; the queued byte is never sent; the next accepted byte 0x3C is sent correctly.
- Loopback at default parameters: drive `tx` into `uart_receiver.dataValue` and send 0x3C, 0x81, 0xFF in sequence → receiver `data` equals each byte after its frame.
- Reset values: with `rst` held high for 3 cycles and `tx_valid`=1 → `tx`=1, `tx_ready`=1, `busy`=0, `tx_done`=0, and no byte is accepted until `rst` is released.
